ps2_mouse_decode: RTL and testbench
===================================

Name: ps2_mouse_decode

Overview:
- Downstream consumer of the PS/2 mouse packet reader. Takes the one-cycle packet-complete pulse and the 32-bit packed packet.
- Validates and decodes buttons and signed X/Y/Z movement, including overflow flags.
- Accumulates a screen cursor position clamped to a window, plus a saturating wheel count.
- Feeds the display/cursor logic.

Parameters:
- X_MAX, 639, largest cursor X (minimum is 0).
- Y_MAX, 479, largest cursor Y (minimum is 0).
- X_INIT, 320, cursor X after reset or iClear.
- Y_INIT, 240, cursor Y after reset or iClear.
- PW, 10, width of the cursor position outputs.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- iTrig  in  1  one-cycle pulse: iData holds a complete packet.
- iData  in  32  packet. [7:0] status byte, [15:8] X low byte, [23:16] Y low byte, [31:24] Z byte (extended mode only).
- iEn  in  2  mode, same encoding as the reader. [1] extended (4-byte), else [0] normal (3-byte). 00 means disabled.
- iClear  in  1  recentre cursor, zero wheel.
- oDone  out  1  one-cycle pulse: outputs updated from a valid packet.
- oKey  out  3  {middle, right, left} button state.
- oX  out  PW  cursor X.
- oY  out  PW  cursor Y, screen convention: 0 = top.
- oZ  out  8  signed wheel accumulator.
- oErr  out  8  count of rejected packets.

Behaviour:
- Single clock domain. All regs are reset synchronously when RESET=1. Reset values: oDone=0, oKey=0, oX=X_INIT, oY=Y_INIT, oZ=0, oErr=0, and all pipeline valids 0.
- Packet fields:
  - status bit0 = L, bit1 = R, bit2 = M, bit3 = sync (must be 1).
  - bit4 = X sign, bit5 = Y sign, bit6 = X overflow, bit7 = Y overflow.
  - dX = 9-bit two's complement {bit4, X byte}; dY = {bit5, Y byte}.
  - dZ = sign-extended iData[27:24] (4-bit signed); forced to 0 unless iEn[1]=1.
- Stage S1, the cycle after iTrig:
  - Register the packet and a valid flag.
  - Valid requires sync bit=1 and iEn≠00.
  - Sync bit=0 with iEn≠00: packet rejected, oErr increments and saturates at 255. No other state changes and no oDone.
  - iEn=00: iTrig ignored entirely; oErr does not count.
- Overflow handling in S1: if an axis overflow bit is set, that delta is replaced by +255 (sign=0) or -256 (sign=1).
- Stage S2, the next cycle:
  - nx = oX + dX, computed in signed PW+2 bits, clamped to [0, X_MAX].
  - ny = oY - dY (PS/2 +Y is up), clamped to [0, Y_MAX].
  - oZ = oZ + dZ, saturating to [-128, 127].
  - oKey loads {M, R, L}.
  - oDone = 1 for exactly this cycle.
- Latency: iTrig at cycle N gives oDone high at N+2, with new outputs visible in that same cycle.
- Back-to-back iTrig on consecutive cycles is accepted. Each packet is applied in order; S2 always uses the position registered by the previous packet.
- iClear:
  - oX=X_INIT, oY=Y_INIT, oZ=0 on the next edge. oKey and oErr are kept.
  - Any packet in S1 or S2 in that cycle is discarded, with no oDone.
  - iClear together with iTrig: clear wins and the packet is dropped.
- RESET in mid-pipeline discards in-flight packets; no oDone follows.
- Mode change between packets is allowed. dZ gating uses the iEn sampled with that packet's iTrig.

Test Plan:
- Reset, then iEn=01, iTrig with iData=0x00_05_0A_09 → oDone at N+2, oKey=001, oX=330, oY=235, oZ=0.
- Start at oX=5; iTrig iData=0x00_00_F0_18 (dX=-16) → oX=0 (clamped). Then dX=+255 with X_MAX=639 applied three times → oX=639 and it stays there.
- iEn=10, four packets each Z nibble 0x7 → oZ = 7, 14, 21, 28. Then Z=0x8 (-8) repeated 30 times → oZ saturates at -128. Same Z with iEn=01 → oZ unchanged.
- Status 0x00 (sync=0) → no oDone, oErr 0→1, position unchanged. 260 such packets → oErr=255.
- Status 0x48 (X overflow, sign 0), X byte 0x00 → dX=+255, oX=320→575.
- iTrig on two consecutive cycles, dX=+1 then +2 → two oDone pulses at N+2 and N+3, oX=321 then 323. iClear asserted with a third iTrig → no oDone, oX=320, oY=240, oZ=0.

Source files
------------

// File: rtl/ps2_mouse_decode_if.sv
// Packet-in / cursor-state-out bundle between the PS/2 packet reader side and the decoder.
interface ps2_mouse_decode_if #(
  parameter int PW = 10
);
  logic          iTrig;
  logic [31:0]   iData;
  logic [1:0]    iEn;
  logic          iClear;
  logic          oDone;
  logic [2:0]    oKey;
  logic [PW-1:0] oX;
  logic [PW-1:0] oY;
  logic [7:0]    oZ;
  logic [7:0]    oErr;

  modport master (
    output iTrig, iData, iEn, iClear,
    input  oDone, oKey, oX, oY, oZ, oErr
  );

  modport slave (
    input  iTrig, iData, iEn, iClear,
    output oDone, oKey, oX, oY, oZ, oErr
  );
endinterface

// File: rtl/ps2_mouse_decode.sv
// Two-stage PS/2 mouse packet decoder: validate/extract deltas, then apply them to a
// clamped cursor position and a saturating wheel count.
module ps2_mouse_decode #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int PW     = 10
) (
  input logic             CLOCK,
  input logic             RESET,
  ps2_mouse_decode_if.slave bus
);
  localparam int W = PW + 2;
  localparam logic signed [W-1:0] XMAX_S = W'(X_MAX);
  localparam logic signed [W-1:0] YMAX_S = W'(Y_MAX);

  logic               s1_valid;
  logic signed [8:0]  s1_dx, s1_dy;
  logic signed [7:0]  s1_dz;
  logic [2:0]         s1_key;

  logic               done_q;
  logic [2:0]         key_q;
  logic [PW-1:0]      x_q, y_q;
  logic signed [7:0]  z_q;
  logic [7:0]         err_q;

  logic               trig_ok;
  logic signed [8:0]  dx_in, dy_in;
  logic signed [7:0]  dz_in;
  logic signed [W-1:0] sx, sy;
  logic signed [8:0]  sz;
  logic [PW-1:0]      nx, ny;
  logic signed [7:0]  nz;
  logic               unused_bits;

  assign unused_bits = ^bus.iData[31:28];

  // Clear takes priority over an arriving packet, so it is simply never accepted.
  assign trig_ok = bus.iTrig && (bus.iEn != 2'b00) && !bus.iClear;

  always_comb begin
    dx_in = $signed({bus.iData[4], bus.iData[15:8]});
    dy_in = $signed({bus.iData[5], bus.iData[23:16]});
    if (bus.iData[6]) dx_in = bus.iData[4] ? 9'h100 : 9'h0FF;
    if (bus.iData[7]) dy_in = bus.iData[5] ? 9'h100 : 9'h0FF;
    dz_in = '0;
    if (bus.iEn[1]) dz_in = $signed({{4{bus.iData[27]}}, bus.iData[27:24]});
  end

  // Screen Y grows downward while PS/2 +Y is up, hence the subtraction.
  always_comb begin
    sx = $signed({2'b00, x_q}) + W'(s1_dx);
    sy = $signed({2'b00, y_q}) - W'(s1_dy);
    sz = 9'(z_q) + 9'(s1_dz);

    nx = sx[PW-1:0];
    if (sx < 0)           nx = '0;
    else if (sx > XMAX_S) nx = PW'(X_MAX);

    ny = sy[PW-1:0];
    if (sy < 0)           ny = '0;
    else if (sy > YMAX_S) ny = PW'(Y_MAX);

    nz = sz[7:0];
    if (sz > 9'sd127)       nz = 8'sh7F;
    else if (sz < -9'sd128) nz = 8'sh80;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_dz    <= '0;
      s1_key   <= '0;
      done_q   <= 1'b0;
      key_q    <= '0;
      x_q      <= PW'(X_INIT);
      y_q      <= PW'(Y_INIT);
      z_q      <= '0;
      err_q    <= '0;
    end else begin
      s1_valid <= trig_ok && bus.iData[3];
      if (trig_ok) begin
        s1_dx  <= dx_in;
        s1_dy  <= dy_in;
        s1_dz  <= dz_in;
        s1_key <= bus.iData[2:0];
      end
      if (trig_ok && !bus.iData[3] && err_q != 8'hFF) err_q <= err_q + 8'd1;

      done_q <= 1'b0;
      if (bus.iClear) begin
        x_q <= PW'(X_INIT);
        y_q <= PW'(Y_INIT);
        z_q <= '0;
      end else if (s1_valid) begin
        x_q    <= nx;
        y_q    <= ny;
        z_q    <= nz;
        key_q  <= {s1_key[2], s1_key[1], s1_key[0]};
        done_q <= 1'b1;
      end
    end
  end

  assign bus.oDone = done_q;
  assign bus.oKey  = key_q;
  assign bus.oX    = x_q;
  assign bus.oY    = y_q;
  assign bus.oZ    = z_q;
  assign bus.oErr  = err_q;
endmodule

// File: tb/tb_ps2_mouse_decode.sv
// Scoreboard bench for ps2_mouse_decode: a behavioural model queues expected results per packet.
module tb_ps2_mouse_decode;
  localparam int PW = 10, X_MAX = 639, Y_MAX = 479, X_INIT = 320, Y_INIT = 240;

  logic CLOCK = 1'b0;
  logic RESET;
  ps2_mouse_decode_if #(.PW(PW)) bus();

  ps2_mouse_decode #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .PW(PW)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int cyc; int key; int x; int y; int z;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0;
  int mx = X_INIT, my = Y_INIT, mz = 0, merr = 0, mkey = 0;
  int ndone_exp = 0, ndone_seen = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(negedge CLOCK) begin
    if (!RESET && bus.oDone) begin
      ndone_seen++;
      if (sbq.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        check("latency", cyc, e.cyc);
        check("key", int'(bus.oKey), e.key);
        check("x", int'(bus.oX), e.x);
        check("y", int'(bus.oY), e.y);
        check("z", int'($signed(bus.oZ)), e.z);
      end
    end
  end

  task automatic drive(input logic trig, input logic [31:0] d, input logic [1:0] en,
                       input logic clr);
    bus.iTrig  = trig;
    bus.iData  = d;
    bus.iEn    = en;
    bus.iClear = clr;
    @(negedge CLOCK);
    bus.iTrig  = 1'b0;
    bus.iData  = '0;
    bus.iClear = 1'b0;
  endtask

  task automatic pkt(input logic [31:0] d, input logic [1:0] en);
    int dx, dy, dz;
    if (en != 2'b00) begin
      if (d[3]) begin
        dx = int'(d[15:8]) - (d[4] ? 256 : 0);
        dy = int'(d[23:16]) - (d[5] ? 256 : 0);
        if (d[6]) dx = d[4] ? -256 : 255;
        if (d[7]) dy = d[5] ? -256 : 255;
        dz = 0;
        if (en[1]) begin
          dz = int'(d[27:24]);
          if (dz >= 8) dz -= 16;
        end
        mx   = clampi(mx + dx, 0, X_MAX);
        my   = clampi(my - dy, 0, Y_MAX);
        mz   = clampi(mz + dz, -128, 127);
        mkey = int'(d[2:0]);
        sbq.push_back('{cyc + 2, mkey, mx, my, mz});
        ndone_exp++;
      end else if (merr < 255) merr++;
    end
    drive(1'b1, d, en, 1'b0);
  endtask

  task automatic model_clear();
    mx = X_INIT; my = Y_INIT; mz = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_done"}, int'(bus.oDone), 0);
    check({tag, "_key"}, int'(bus.oKey), mkey);
    check({tag, "_x"}, int'(bus.oX), mx);
    check({tag, "_y"}, int'(bus.oY), my);
    check({tag, "_z"}, int'($signed(bus.oZ)), mz);
    check({tag, "_err"}, int'(bus.oErr), merr);
  endtask

  initial begin
    RESET = 1'b1;
    bus.iTrig = 1'b0; bus.iData = '0; bus.iEn = 2'b00; bus.iClear = 1'b0;
    idle(3);
    RESET = 1'b0;
    check_state("reset");

    pkt(32'h00050A09, 2'b01);
    idle(3);
    check_state("basic");

    pkt(32'h00000018, 2'b01); idle(3);
    pkt(32'h0000BB18, 2'b01); idle(3);
    check("x_at_5", int'(bus.oX), 5);
    pkt(32'h0000F018, 2'b01); idle(3);
    check("x_clamp_lo", int'(bus.oX), 0);
    repeat (4) begin pkt(32'h0000FF08, 2'b01); idle(3); end
    check("x_clamp_hi", int'(bus.oX), X_MAX);

    pkt(32'h00FF0008, 2'b01); idle(3);
    check("y_clamp_lo", int'(bus.oY), 0);
    repeat (3) begin pkt(32'h00000028, 2'b01); idle(3); end
    check("y_clamp_hi", int'(bus.oY), Y_MAX);

    repeat (4) begin pkt(32'h07000008, 2'b10); idle(3); end
    check("z_28", int'($signed(bus.oZ)), 28);
    repeat (30) begin pkt(32'h08000008, 2'b10); idle(2); end
    idle(2);
    check("z_sat", int'($signed(bus.oZ)), -128);
    pkt(32'h07000008, 2'b01); idle(3);
    check_state("z_gated");

    pkt(32'h00000000, 2'b01); idle(3);
    check_state("err1");
    pkt(32'h00000000, 2'b00); idle(3);
    check_state("disabled");
    repeat (260) pkt(32'h00000000, 2'b01);
    idle(3);
    check("err_sat", int'(bus.oErr), 255);

    model_clear();
    drive(1'b0, 32'h0, 2'b01, 1'b1);
    idle(2);
    check_state("clear");
    pkt(32'h00000048, 2'b01); idle(3);
    check("x_ovf", int'(bus.oX), 575);

    model_clear();
    drive(1'b0, 32'h0, 2'b01, 1'b1);
    pkt(32'h00000108, 2'b01);
    pkt(32'h00000208, 2'b01);
    idle(3);
    check("x_b2b", int'(bus.oX), 323);
    model_clear();
    drive(1'b1, 32'h00000108, 2'b01, 1'b1);
    idle(3);
    check_state("clear_trig");

    drive(1'b1, 32'h00000308, 2'b01, 1'b0);
    model_clear();
    drive(1'b0, 32'h0, 2'b01, 1'b1);
    idle(3);
    check_state("clear_mid");

    drive(1'b1, 32'h00000308, 2'b01, 1'b0);
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    model_clear(); mkey = 0; merr = 0;
    idle(3);
    check_state("reset_mid");

    pkt(32'h00000508, 2'b01);
    idle(4);
    check("sb_empty", sbq.size(), 0);
    check("done_count", ndone_seen, ndone_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
